// File: rtl/lsu_pkg.sv
// Shared types for the byte-wide load/store sequencer: FSM states,
// request size encodings and the size-to-byte-count mapping.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 is handled as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Zero/sign extension of assembled little-endian load data by access size.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  // Fill above the loaded bytes with zeros, or with the top loaded bit when signed.
  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_W-8){signed_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{(DATA_W-16){signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits byte/half/word requests into single-byte
// memory accesses (little-endian), assembles load data and returns one
// response per request.
// Build option LSU_MISALIGN_ERR_EN: misaligned half/word requests return
// resp_err=1 without touching memory; otherwise they run byte-wise.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | one memory byte access per cycle, rem_q counts down to the last
// RESP   | response held until resp_ready
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int KW = $clog2(DATA_W/8);

  lsu_state_e        state_q;
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic [1:0]        size_q;
  logic              signed_q, write_q;
  logic [DATA_W-1:0] wdata_q, asm_q, asm_d, ext_data;
  logic [KW-1:0]     k_q, k_nxt, rem_q;
  logic              misalign;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign memRead    = mem_read_q;
  assign memWrite   = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  assign k_nxt = k_q + KW'(1);

`ifdef LSU_MISALIGN_ERR_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size[1] == 1'b1) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Merge the byte returned this cycle into its lane of the assembly register.
  always_comb begin
    asm_d = asm_q;
    asm_d[{k_q, 3'b000} +: 8] = mem_rdata;
  end

  lsu_load_extend #(.DATA_W(DATA_W)) u_extend (
    .data_i   (asm_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  // Sequencer FSM with all outputs registered; memory strobes depend only on latched state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      asm_q        <= '0;
      k_q          <= '0;
      rem_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            size_q      <= req_size;
            signed_q    <= req_signed;
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            asm_q       <= '0;
            k_q         <= '0;
            rem_q       <= KW'(size_bytes(req_size) - 3'd1);
            if (misalign) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              resp_err_q  <= 1'b0;
              mem_read_q  <= !req_write;
              mem_write_q <= req_write;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          asm_q <= asm_d;
          if (rem_q == '0) begin
            state_q      <= RESP;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? '0 : ext_data;
          end else begin
            rem_q       <= rem_q - KW'(1);
            k_q         <= k_nxt;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= wdata_q[{k_nxt, 3'b000} +: 8];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        memRead, memWrite;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // 16-byte memory decoding only the low address bits
  logic [7:0] mem     [16];
  logic [7:0] ref_mem [16];

  // observations from the driver
  logic [31:0] obs_rd;
  logic        obs_err;
  int          obs_lat;
  bit          obs_stable, obs_after_valid, obs_after_ready, obs_resp_rdy;
  logic [41:0] tr_q[$];
  // model expectations
  logic [31:0] exp_rd;
  logic        exp_err;
  int          exp_lat;
  logic [41:0] exp_tr[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (memWrite) mem[mem_addr[3:0]] <= mem_wdata;

  lsu_byte_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .memRead(memRead),
    .memWrite(memWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_ERR_EN
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: what a request should do to memory and what it should return.
  task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    logic [31:0] val = 32'h0;
    logic [31:0] ad;
    exp_tr.delete();
    if (misaligned(sz, a)) begin
      exp_err = 1'b1; exp_rd = 32'h0; exp_lat = 0;
      return;
    end
    exp_err = 1'b0; exp_lat = n;
    for (int i = 0; i < n; i++) begin
      ad = a + 32'(i);
      if (w) begin
        exp_tr.push_back({2'b01, ad, wd[8*i +: 8]});
        ref_mem[ad[3:0]] = wd[8*i +: 8];
      end else begin
        exp_tr.push_back({2'b10, ad, 8'h00});
        val = val | (32'(ref_mem[ad[3:0]]) << (8*i));
      end
    end
    if (w) exp_rd = 32'h0;
    else if (n < 4 && sg && val[8*n-1]) exp_rd = val | (32'hFFFF_FFFF << (8*n));
    else exp_rd = val;
  endtask

  // Drives one request from a negedge and records what the DUT does.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
    int c;
    logic [41:0] e;
    tr_q.delete();
    obs_stable = 1'b1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    c = 0;
    while (!req_ready && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    c = 0;
    while (!resp_valid && c < 20) begin
      if (memRead || memWrite) begin
        e = {memRead, memWrite, mem_addr, mem_wdata};
        if (memRead) e[7:0] = 8'h00;
        tr_q.push_back(e);
      end
      @(negedge clk); c++;
    end
    obs_lat = resp_valid ? c : -1;
    obs_rd = resp_rdata; obs_err = resp_err; obs_resp_rdy = req_ready;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_rdata !== obs_rd || resp_err !== obs_err || resp_valid !== 1'b1 || req_ready !== 1'b0)
        obs_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    obs_after_valid = resp_valid;
    obs_after_ready = req_ready;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b1; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, memRead, memWrite} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h, all must be 0",
               req_ready, resp_valid, resp_err, memRead, memWrite, resp_rdata, mem_addr, mem_wdata);
    end
    req_valid = 1'b0; resp_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_load;
    model_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0);
    checks++;
    if (obs_rd !== 32'h04030201) begin errors++; $display("FAIL word_load_data: got %h want 04030201", obs_rd); end
    checks++;
    if (obs_lat != 4) begin errors++; $display("FAIL word_load_latency: got %0d want 4", obs_lat); end
    checks++;
    if (tr_q.size() != 4) begin errors++; $display("FAIL word_load_strobes: got %0d cycles want 4", tr_q.size()); end
    for (int i = 0; i < 4 && i < tr_q.size(); i++) begin
      checks++;
      if (tr_q[i] !== {2'b10, 32'(i), 8'h00}) begin
        errors++; $display("FAIL word_load_access%0d: got %h want %h", i, tr_q[i], {2'b10, 32'(i), 8'h00});
      end
    end
  endtask

  task automatic test_store_load;
    logic [7:0] b [4];
    b[0] = 8'hEF; b[1] = 8'hBE; b[2] = 8'hAD; b[3] = 8'hDE;
    model_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF);
    run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 0);
    checks++;
    if (tr_q.size() != 4) begin errors++; $display("FAIL store_strobes: got %0d cycles want 4", tr_q.size()); end
    for (int i = 0; i < 4 && i < tr_q.size(); i++) begin
      checks++;
      if (tr_q[i] !== {2'b01, 32'(4 + i), b[i]}) begin
        errors++; $display("FAIL store_access%0d: got %h want %h", i, tr_q[i], {2'b01, 32'(4 + i), b[i]});
      end
    end
    checks++;
    if (obs_rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", obs_rd); end
    model_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0);
    checks++;
    if (obs_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_readback: got %h want deadbeef", obs_rd); end
  endtask

  task automatic test_byte_sign;
    model_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000080);
    run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000080, 0);
    model_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    run_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 0);
    checks++;
    if (obs_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed: got %h want ffffff80", obs_rd); end
    model_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    run_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 0);
    checks++;
    if (obs_rd !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned: got %h want 00000080", obs_rd); end
  endtask

  task automatic test_misaligned;
    model_req(1'b0, 2'b10, 1'b0, 32'hE, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'hE, 32'h0, 0);
`ifdef LSU_MISALIGN_ERR_EN
    checks++;
    if (obs_err !== 1'b1 || obs_rd !== 32'h0 || tr_q.size() != 0) begin
      errors++; $display("FAIL misaligned_err: err=%b rdata=%h strobes=%0d want 1/0/0", obs_err, obs_rd, tr_q.size());
    end
`else
    checks++;
    if (obs_rd !== 32'h0201100F || obs_err !== 1'b0) begin
      errors++; $display("FAIL misaligned_word: got %h err %b want 0201100f err 0", obs_rd, obs_err);
    end
    checks++;
    if (tr_q.size() != 4 || tr_q[2][39:8] !== 32'h10 || tr_q[3][39:8] !== 32'h11) begin
      errors++; $display("FAIL misaligned_addrs: %0d accesses, want 4 ending at 0x10,0x11", tr_q.size());
    end
`endif
  endtask

  task automatic test_backpressure;
    model_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 3);
    checks++;
    if (obs_rd !== 32'h00000403) begin errors++; $display("FAIL bp_data: got %h want 00000403", obs_rd); end
    checks++;
    if (!obs_stable || obs_resp_rdy) begin errors++; $display("FAIL bp_hold: stable=%b ready_in_resp=%b want 1/0", obs_stable, obs_resp_rdy); end
    checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: resp_valid=%b req_ready=%b want 0/1", obs_after_valid, obs_after_ready);
    end
  endtask

  task automatic test_reset_abort;
    bit saw_rv = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h1122335A;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (memWrite !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 8'h5A) begin
      errors++; $display("FAIL abort_first: wr=%b addr=%h data=%h want 1/0/5a", memWrite, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    ref_mem[0] = 8'h5A;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, memRead, memWrite} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 8'h0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL abort_reset_state: rdy=%b rv=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
                         req_ready, resp_valid, memWrite, mem_addr, mem_wdata, resp_rdata);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    repeat (4) begin @(negedge clk); if (resp_valid) saw_rv = 1'b1; end
    checks++;
    if (saw_rv) begin errors++; $display("FAIL abort_no_resp: resp_valid seen, want none"); end
  endtask

  task automatic test_random;
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          hold;
    for (int r = 0; r < 60; r++) begin
      w = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      wd = $urandom; hold = $urandom_range(0, 3);
      model_req(w, sz, sg, a, wd);
      run_req(w, sz, sg, a, wd, hold);
      checks++;
      if (obs_rd !== exp_rd || obs_err !== exp_err) begin
        errors++; $display("FAIL rand%0d_resp: rdata=%h err=%b want %h/%b", r, obs_rd, obs_err, exp_rd, exp_err);
      end
      checks++;
      if (obs_lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", r, obs_lat, exp_lat); end
      checks++;
      if (tr_q.size() != exp_tr.size()) begin
        errors++; $display("FAIL rand%0d_strobes: got %0d accesses want %0d", r, tr_q.size(), exp_tr.size());
      end
      for (int i = 0; i < exp_tr.size() && i < tr_q.size(); i++) begin
        checks++;
        if (tr_q[i] !== exp_tr[i]) begin
          errors++; $display("FAIL rand%0d_access%0d: got %h want %h", r, i, tr_q[i], exp_tr[i]);
        end
      end
      checks++;
      if (!obs_stable || obs_resp_rdy || obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_handshake: stable=%b rdy_in_resp=%b rv_after=%b rdy_after=%b want 1/0/0/1",
                           r, obs_stable, obs_resp_rdy, obs_after_valid, obs_after_ready);
      end
    end
  endtask

  task automatic test_memory_image;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL mem_image[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'(i + 1);
      ref_mem[i] = 8'(i + 1);
    end
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_word_load;
    test_misaligned;
    test_backpressure;
    test_store_load;
    test_byte_sign;
    test_reset_abort;
    test_random;
    test_memory_image;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
